// File: rtl/mul_pkg.sv
// Shared types and helpers for the mul_sa shift-and-add multiplier.
// State encoding, default operand width and the step-counter width function.
package mul_pkg;

  localparam int MUL_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  // Bits needed to hold a remaining-step count from 0 up to width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_sa_if.sv
// Request/result bundle for mul_sa; master drives operands, slave is the multiplier.
//
// Handshake: go is a one-cycle start strobe, accepted only while the unit is idle
// (busy=0); there is no ready and no queueing, a go seen while busy is dropped.
// done is a one-cycle result pulse; p is valid from that cycle and holds until the
// next done. state mirrors the controller FSM for debug visibility.
interface mul_sa_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
);

  localparam int CW = cnt_width(WIDTH);

  logic                 go;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;
  logic [CW-1:0]        cnt_out;
  logic [1:0]           state;

  modport master (
    output go,
    output x,
    output y,
    input  busy,
    input  done,
    input  p,
    input  cnt_out,
    input  state
  );

  modport slave (
    input  go,
    input  x,
    input  y,
    output busy,
    output done,
    output p,
    output cnt_out,
    output state
  );

endinterface

// File: rtl/mul_dp.sv
// Shift-and-add datapath: multiplicand/multiplier shifters, accumulator adder
// and the remaining-step counter, driven by ld/step from the mul_sa controller.
module mul_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld,
  input  logic                 step,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 b_zero,
  output logic                 cnt_zero,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic [CW-1:0]        cnt
);

  logic [2*WIDTH-1:0] a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] a_shift;
  logic [WIDTH-1:0]   b_shift;
  logic [CW-1:0]      cnt_dec;

  // The product of two WIDTH-bit values fits in 2*WIDTH bits, so the sum never carries out.
  always_comb begin
    acc_sum = acc_q;
    if (b_q[0]) begin
      acc_sum = acc_q + a_q;
    end
    a_shift = a_q << 1;
    b_shift = b_q >> 1;
    cnt_dec = cnt_q - CW'(1);
  end

  // Status reflects the values the current step produces, so the controller
  // can leave CALC on the same edge that performs the final step.
  assign b_zero   = (b_shift == '0);
  assign cnt_zero = (cnt_dec == '0);
  assign acc_next = acc_sum;
  assign cnt      = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (ld) begin
      a_q   <= {{WIDTH{1'b0}}, x};
      b_q   <= y;
      acc_q <= '0;
      cnt_q <= CW'(WIDTH);
    end else if (step) begin
      a_q   <= a_shift;
      b_q   <= b_shift;
      acc_q <= acc_sum;
      cnt_q <= cnt_dec;
    end
  end

endmodule

// File: rtl/mul_sa.sv
// Sequential unsigned shift-and-add multiplier: FSM, operand staging, busy/done and p.
// Build option MUL_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module mul_sa
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic     CLK,
  input  logic     RST,
  mul_sa_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]          state_q;
  logic [1:0]          state_nxt;
  logic [WIDTH-1:0]    x_stage;
  logic [WIDTH-1:0]    y_stage;
  logic                busy_q;
  logic                done_q;
  logic [2*WIDTH-1:0]  p_q;

  logic                ld;
  logic                step;
  logic                b_zero;
  logic                cnt_zero;
  logic                calc_exit;
  logic [2*WIDTH-1:0]  acc_next;
  logic [CW-1:0]       cnt;

  mul_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk      (CLK),
    .rst      (RST),
    .ld       (ld),
    .step     (step),
    .x        (x_stage),
    .y        (y_stage),
    .b_zero   (b_zero),
    .cnt_zero (cnt_zero),
    .acc_next (acc_next),
    .cnt      (cnt)
  );

  assign ld   = (state_q == LOAD);
  assign step = (state_q == CALC);

`ifdef MUL_EARLY_EXIT_EN
  assign calc_exit = cnt_zero | b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign calc_exit     = cnt_zero;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.go) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    if (calc_exit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so both are plain registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      x_stage <= '0;
      y_stage <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      if ((state_q == IDLE) && bus.go) begin
        x_stage <= bus.x;
        y_stage <= bus.y;
      end
      // Capture the post-step sum so p is already valid in the DONE cycle.
      if ((state_q == CALC) && calc_exit) begin
        p_q <= acc_next;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.p       = p_q;
  assign bus.cnt_out = cnt;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mul_sa.sv
// Self-checking bench for mul_sa: vector table plus hand-written corner sequences,
// products checked through an expected-result queue on every done pulse.
module tb_mul_sa;
  import mul_pkg::*;

  localparam int W  = 4;
  localparam int CW = cnt_width(W);

  logic clk;
  logic rst;

  mul_sa_if #(.WIDTH(W)) bus ();

  mul_sa #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: act=%0d req=%0d", nm, act, req);
    end
  endtask

  function automatic int exp_steps(input logic [W-1:0] yv);
    int k;
`ifdef MUL_EARLY_EXIT_EN
    int bl;
    bl = 0;
    for (int i = 0; i < W; i++) if (yv[i]) bl = i + 1;
    k = (bl < 1) ? 1 : bl;
`else
    k = W;
`endif
    return k;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: act=done req=no_done p=%0d", bus.p);
      end else begin
        chk("product", 32'(bus.p), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives go for cycle 0 and returns inside cycle 1 (just after the edge).
  task automatic start_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [2*W-1:0] pv);
    @(posedge clk); #1;
    bus.go = 1'b1;
    bus.x  = xv;
    bus.y  = yv;
    exp_q.push_back(pv);
    @(posedge clk); #1;
    bus.go = 1'b0;
    bus.x  = W'($urandom_range(0, 15));
    bus.y  = W'($urandom_range(0, 15));
  endtask

  // Waits from cycle start_c for done; returns at the negedge of the done cycle.
  task automatic wait_done(input int start_c, output int done_c);
    done_c = -1;
    for (int c = start_c; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("p_hold_on_go", 32'(bus.p), 32'(last_p));
      if (c == 2) chk("cnt_first_calc", 32'(bus.cnt_out), W);
      if (bus.done === 1'b1) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_c < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: act=none req=done");
    end
  endtask

  // Checks the cycle after done: idle again, p held.
  task automatic check_after(input string tag, input logic [2*W-1:0] pv);
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_low"}, 32'(bus.busy), 0);
    chk({tag, "_p_held"}, 32'(bus.p), 32'(pv));
    last_p = pv;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [2*W-1:0] pv);
    int dc;
    int k;
    k = exp_steps(yv);
    start_op(xv, yv, pv);
    wait_done(1, dc);
    chk({tag, "_latency"}, 32'(dc), 32'(k + 2));
    chk({tag, "_cnt_at_done"}, 32'(bus.cnt_out), 32'(W - k));
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 1);
    check_after(tag, pv);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int dc;
    logic [W-1:0] rx, ry;

    vecs[0] = '{x: 4'd3,  y: 4'd5,  p: 8'd15};
    vecs[1] = '{x: 4'd15, y: 4'd15, p: 8'd225};
    vecs[2] = '{x: 4'd9,  y: 4'd0,  p: 8'd0};
    vecs[3] = '{x: 4'd0,  y: 4'd9,  p: 8'd0};
    vecs[4] = '{x: 4'd1,  y: 4'd1,  p: 8'd1};
    vecs[5] = '{x: 4'd8,  y: 4'd2,  p: 8'd16};
    vecs[6] = '{x: 4'd15, y: 4'd1,  p: 8'd15};
    vecs[7] = '{x: 4'd10, y: 4'd12, p: 8'd120};
    vecs[8] = '{x: 4'd6,  y: 4'd7,  p: 8'd42};
    vecs[9] = '{x: 4'd2,  y: 4'd8,  p: 8'd16};

    rst    = 1'b1;
    bus.go = 1'b0;
    bus.x  = '0;
    bus.y  = '0;
    last_p = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_p", 32'(bus.p), 0);
    chk("rst_cnt", 32'(bus.cnt_out), 0);
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].p);
    end

    for (int i = 0; i < 8; i++) begin
      rx = W'($urandom_range(0, 15));
      ry = W'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), rx, ry, (2*W)'(rx) * (2*W)'(ry));
    end

    // go re-pulsed with new operands mid-CALC must be dropped.
    start_op(4'd7, 4'd6, 8'd42);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.go = 1'b1;
    bus.x  = 4'd1;
    bus.y  = 4'd1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    wait_done(4, dc);
    chk("repulse_latency", 32'(dc), 32'(exp_steps(4'd6) + 2));
    check_after("repulse", 8'd42);
    repeat (10) @(posedge clk);
    chk("repulse_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-CALC: operation abandoned, p cleared, no done.
    @(posedge clk); #1;
    bus.go = 1'b1;
    bus.x  = 4'd15;
    bus.y  = 4'd15;
    @(posedge clk); #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_p", 32'(bus.p), 0);
    chk("midrst_done", 32'(bus.done), 0);
    last_p = '0;
    repeat (10) @(posedge clk);
    run_op("after_rst", 4'd2, 4'd7, 8'd14);

    // Reset and go in the same cycle: go is lost.
    @(posedge clk); #1;
    rst    = 1'b1;
    bus.go = 1'b1;
    bus.x  = 4'd5;
    bus.y  = 4'd5;
    @(posedge clk); #1;
    rst    = 1'b0;
    bus.go = 1'b0;
    @(negedge clk);
    chk("rstgo_busy", 32'(bus.busy), 0);
    chk("rstgo_state", 32'(bus.state), 32'(ST_IDLE));
    last_p = '0;

    // Back-to-back: second go lands in the first idle cycle after done.
    run_op("b2b_a", 4'd4, 4'd4, 8'd16);
    run_op("b2b_b", 4'd5, 4'd3, 8'd15);

    repeat (12) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
